// File: rtl/sram_arbiter.sv
// Three-way round-robin SRAM port arbiter with optional burst lock,
// registered SRAM command outputs and read-return tagging per requester.
module sram_arbiter #(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_LOCK     = 256
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [2:0]          req_valid,
  input  logic [2:0]          req_lock,
  input  logic [2:0]          req_we_n,
  input  logic [3*ADDR_W-1:0] req_address,
  input  logic [3*DATA_W-1:0] req_write_data,
  output logic [2:0]          grant,
  output logic [2:0]          rd_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]   SRAM_address,
  output logic [DATA_W-1:0]   SRAM_write_data,
  output logic                SRAM_we_n,
  input  logic [DATA_W-1:0]   SRAM_read_data
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LOCK);

  typedef enum logic {FREE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               we_n_q, we_n_d;
  logic               cmd_rd_q, cmd_rd_d;
  logic [1:0]         cmd_id_q, cmd_id_d;
  logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [1:0]         pipe_id_q [READ_LATENCY];
  logic [1:0]         pipe_id_d [READ_LATENCY];
  logic [1:0]         win, c0, c1, c2;
  logic               win_vld;

  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Arbitration and lock FSM
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    win        = 2'd0;
    win_vld    = 1'b0;
    cnt_inc    = lock_cnt_q + CNT_W'(1);
    c0         = rr_next(last_q);
    c1         = rr_next(c0);
    c2         = last_q;
    case (state_q)
      FREE: begin
        if (req_valid[c0]) begin
          win = c0; win_vld = 1'b1;
        end else if (req_valid[c1]) begin
          win = c1; win_vld = 1'b1;
        end else if (req_valid[c2]) begin
          win = c2; win_vld = 1'b1;
        end
        if (win_vld) begin
          last_d = win;
          if (req_lock[win] && (MAX_LOCK > 1)) begin
            state_d    = OWNED;
            owner_d    = win;
            lock_cnt_d = CNT_W'(1);
          end
        end
      end
      default: begin
        // The owner skipping a cycle always releases, producing one idle bubble
        state_d = FREE;
        if (req_valid[owner_q]) begin
          win        = owner_q;
          win_vld    = 1'b1;
          last_d     = owner_q;
          lock_cnt_d = cnt_inc;
          if (req_lock[owner_q] && (cnt_inc < MAX_CNT)) state_d = OWNED;
        end
      end
    endcase
    if (!Resetn) win_vld = 1'b0;
    grant = win_vld ? (3'b001 << win) : 3'b000;
  end

  // Command stage: next SRAM command and read tag
  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_n_d   = 1'b1;
    cmd_rd_d = 1'b0;
    cmd_id_d = win;
    if (win_vld) begin
      addr_d   = req_address[win*ADDR_W +: ADDR_W];
      wdata_d  = req_write_data[win*DATA_W +: DATA_W];
      we_n_d   = req_we_n[win];
      cmd_rd_d = req_we_n[win];
    end
  end

  // Read-return stages: tag travels READ_LATENCY cycles behind the command
  always_comb begin
    pipe_vld_d[0] = cmd_rd_q;
    pipe_id_d[0]  = cmd_id_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= FREE;
      owner_q    <= 2'd0;
      last_q     <= 2'd2;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_n_q     <= 1'b1;
      cmd_rd_q   <= 1'b0;
      pipe_vld_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_n_q     <= we_n_d;
      cmd_rd_q   <= cmd_rd_d;
      pipe_vld_q <= pipe_vld_d;
    end
  end

  always_ff @(posedge Clock) begin
    cmd_id_q <= cmd_id_d;
    for (int i = 0; i < READ_LATENCY; i++) pipe_id_q[i] <= pipe_id_d[i];
  end

  assign SRAM_address    = addr_q;
  assign SRAM_write_data = wdata_q;
  assign SRAM_we_n       = we_n_q;
  assign rd_valid = pipe_vld_q[READ_LATENCY-1] ? (3'b001 << pipe_id_q[READ_LATENCY-1]) : 3'b000;
  assign rd_data  = SRAM_read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: round-robin, lock, forced release,
// write/read mix, read tagging and mid-operation reset.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic          Clock, Resetn;
  logic [2:0]    req_valid, req_lock, req_we_n;
  logic [AW-1:0] a  [3];
  logic [DW-1:0] wd [3];
  logic [3*AW-1:0] req_address;
  logic [3*DW-1:0] req_write_data;
  logic [2:0]    grant, rd_valid;
  logic [DW-1:0] rd_data, SRAM_write_data, SRAM_read_data;
  logic [AW-1:0] SRAM_address;
  logic          SRAM_we_n;
  logic [AW-1:0] a1, a2;

  int total = 0;
  int bad   = 0;

  logic [2:0]    rr_g [6] = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4};
  logic [AW-1:0] rr_a [6] = '{18'd10, 18'd20, 18'd30, 18'd10, 18'd20, 18'd30};
  logic [2:0]    t3v  [7] = '{3'd7, 3'd7, 3'd7, 3'd7, 3'd5, 3'd1, 3'd0};
  logic [2:0]    t3l  [7] = '{3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [2:0]    t3g  [7] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd1, 3'd0};
  logic [2:0]    t4v  [8] = '{3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd0, 3'd0};
  logic [2:0]    t4g  [8] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd4, 3'd0, 3'd0};

  assign req_address    = {a[2], a[1], a[0]};
  assign req_write_data = {wd[2], wd[1], wd[0]};

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .MAX_LOCK(4)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req_valid(req_valid), .req_lock(req_lock), .req_we_n(req_we_n),
    .req_address(req_address), .req_write_data(req_write_data),
    .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [DW-1:0] sram_f(input logic [AW-1:0] ad);
    return (ad == 18'd38400) ? 16'hA5A5 : (ad[15:0] ^ 16'hC3C3);
  endfunction

  // Two-cycle SRAM: data for the address presented in cycle t appears in t+2
  always @(posedge Clock) begin
    a1 <= SRAM_address;
    a2 <= a1;
  end
  assign SRAM_read_data = sram_f(a2);

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    Resetn = 1'b0; req_valid = 3'b000; req_lock = 3'b000; req_we_n = 3'b111;
    for (int k = 0; k < 3; k++) begin a[k] = '0; wd[k] = '0; end
    tick();
    req_valid = 3'b111; #1;
    chk("reset_grant", grant, 0);
    tick();
    chk("reset_we_n", SRAM_we_n, 1);
    chk("reset_addr", SRAM_address, 0);
    chk("reset_wdata", SRAM_write_data, 0);
    chk("reset_rd_valid", rd_valid, 0);
    req_valid = 3'b000;
    Resetn = 1'b1;
    tick();

    // Test 1: single read from requester 0
    req_valid = 3'b001; a[0] = 18'd38400; #1;
    chk("t1_grant", grant, 3'b001);
    tick();
    req_valid = 3'b000; #1;
    chk("t1_grant_idle", grant, 0);
    chk("t1_addr", SRAM_address, 38400);
    chk("t1_we_n", SRAM_we_n, 1);
    tick();
    chk("t1_rd_early", rd_valid, 0);
    tick();
    chk("t1_rd_valid", rd_valid, 3'b001);
    chk("t1_rd_data", rd_data, 16'hA5A5);
    tick();
    chk("t1_rd_after", rd_valid, 0);
    chk("t1_addr_hold", SRAM_address, 38400);

    // Test 2: all three valid from reset
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    a[0] = 18'd10; a[1] = 18'd20; a[2] = 18'd30;
    for (int i = 0; i < 9; i++) begin
      req_valid = (i < 6) ? 3'b111 : 3'b000; #1;
      chk("rr_grant", grant, (i < 6) ? rr_g[i] : 3'b000);
      if (i >= 1 && i <= 6) begin
        chk("rr_addr", SRAM_address, rr_a[i-1]);
        chk("rr_we_n", SRAM_we_n, 1);
      end
      if (i >= 3) begin
        chk("rr_rd_valid", rd_valid, rr_g[i-3]);
        chk("rr_rd_data", rd_data, sram_f(rr_a[i-3]));
      end else begin
        chk("rr_rd_idle", rd_valid, 0);
      end
      tick();
    end

    // Test 3: requester 1 locks for four accesses
    req_valid = 3'b001; #1;
    chk("t3_pre_grant", grant, 3'b001);
    tick();
    for (int j = 0; j < 7; j++) begin
      req_valid = t3v[j]; req_lock = t3l[j]; #1;
      chk("t3_grant", grant, t3g[j]);
      tick();
    end

    // Release bubble: owner drops valid, nobody granted that cycle
    req_valid = 3'b001; req_lock = 3'b001; #1;
    chk("bub_grant_own", grant, 3'b001);
    tick();
    req_valid = 3'b010; req_lock = 3'b000; #1;
    chk("bub_release", grant, 3'b000);
    tick();
    chk("bub_next", grant, 3'b010);
    tick();

    // Test 4: forced release at MAX_LOCK=4
    req_lock = 3'b100;
    for (int j = 0; j < 8; j++) begin
      req_valid = t4v[j]; #1;
      chk("t4_grant", grant, t4g[j]);
      tick();
    end
    req_lock = 3'b000;

    // Test 5: write from 0 then read from 1
    req_valid = 3'b001; req_we_n = 3'b110; a[0] = 18'd146944; wd[0] = 16'h1234; #1;
    chk("t5_wr_grant", grant, 3'b001);
    tick();
    req_valid = 3'b010; req_we_n = 3'b111; a[1] = 18'd0; #1;
    chk("t5_rd_grant", grant, 3'b010);
    chk("t5_wr_we_n", SRAM_we_n, 0);
    chk("t5_wr_addr", SRAM_address, 146944);
    chk("t5_wr_data", SRAM_write_data, 16'h1234);
    chk("t5_rd_idle1", rd_valid, 0);
    tick();
    req_valid = 3'b000; #1;
    chk("t5_rd_we_n", SRAM_we_n, 1);
    chk("t5_rd_addr", SRAM_address, 0);
    chk("t5_rd_idle2", rd_valid, 0);
    tick();
    chk("t5_no_wr_return", rd_valid, 0);
    tick();
    chk("t5_rd_valid", rd_valid, 3'b010);
    chk("t5_rd_data", rd_data, 16'hC3C3);
    tick();

    // Test 6: reset with reads from requester 1 in flight
    req_valid = 3'b010; a[1] = 18'd5; #1;
    chk("t6_grant_a", grant, 3'b010);
    tick();
    a[1] = 18'd6; #1;
    chk("t6_grant_b", grant, 3'b010);
    tick();
    Resetn = 1'b0; #1;
    chk("t6_grant_in_reset", grant, 0);
    tick();
    Resetn = 1'b1; req_valid = 3'b000; #1;
    chk("t6_we_n", SRAM_we_n, 1);
    chk("t6_addr", SRAM_address, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t6_rd_discard", rd_valid, 0);
      tick();
    end
    req_valid = 3'b011; #1;
    chk("t6_first_grant", grant, 3'b001);
    tick();
    req_valid = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external SRAM port between three requesters: 0 = colourspace upsampler (M1), 1 = IDCT/decode engine, 2 = UART/VGA service.
- Round-robin arbitration with optional bus lock for burst sequences.
- Registered SRAM command outputs; per-requester read-return tagging.
- Sits between the milestone datapaths and the SRAM interface in the top level.

Parameters:
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width
READ_LATENCY, 2, cycles from SRAM_address driven to SRAM_read_data valid (1..4)
MAX_LOCK, 256, maximum consecutive cycles one requester may hold a lock

Ports:
Clock  in  1  system clock, all logic on rising edge
Resetn  in  1  synchronous active-low reset
req_valid  in  3  bit i: requester i wants an access this cycle
req_lock  in  3  bit i: keep ownership after this access
req_we_n  in  3  bit i: 0 = write, 1 = read
req_address  in  3*ADDR_W  requester i address in slice [i*ADDR_W +: ADDR_W]
req_write_data  in  3*DATA_W  requester i write data in slice [i*DATA_W +: DATA_W]
grant  out  3  one-hot, combinational; access of requester i accepted this cycle
rd_valid  out  3  one-hot; rd_data belongs to requester i's read this cycle
rd_data  out  DATA_W  combinational copy of SRAM_read_data
SRAM_address  out  ADDR_W  registered address to SRAM
SRAM_write_data  out  DATA_W  registered write data
SRAM_we_n  out  1  registered write enable, active low
SRAM_read_data  in  DATA_W  data returned from SRAM

Behaviour:
- Reset values: SRAM_address=0, SRAM_write_data=0, SRAM_we_n=1, grant=0, rd_valid=0, state=FREE, last=2 (requester 0 wins the first arbitration), lock_cnt=0, read pipeline cleared.
- FSM has two states, FREE and OWNED(owner).
- FREE:
  - Winner is the first valid requester searching (last+1), (last+2), last, modulo 3.
  - grant[winner]=1 in the same cycle.
  - At the next edge: SRAM_address/SRAM_write_data/SRAM_we_n load the winner's fields, and last=winner.
  - If req_lock[winner]=1, go to OWNED(winner) with lock_cnt=1.
- OWNED(o):
  - Only o can be granted. Others see grant=0 and must hold their request stable until granted.
  - If req_valid[o]=1: grant o and issue the access. lock_cnt increments.
  - Stay OWNED only if req_lock[o]=1 and lock_cnt < MAX_LOCK; otherwise return to FREE.
  - If req_valid[o]=0: grant nothing and return to FREE (release bubble, 1 idle cycle).
  - Forced release at MAX_LOCK: the owner's final granted access still issues. The next cycle arbitrates round-robin with last=o, so the other requesters win first.
- Cycles with no grant:
  - SRAM_we_n=1 at the next edge.
  - SRAM_address and SRAM_write_data hold their previous values.
- Read return pipeline:
  - A shift register READ_LATENCY deep carries {valid, id}.
  - A granted read (we_n=1) enters {1,id} when its SRAM command is registered.
  - rd_valid[id] asserts exactly READ_LATENCY cycles after the cycle SRAM_address presented that read.
  - Writes and idle cycles enter {0,x}.
  - rd_valid is one-hot or zero. rd_data is always SRAM_read_data.
- Back-to-back accesses from any mix of requesters issue at 1 per cycle, with no turnaround bubble.
- Simultaneous events:
  - The release cycle of OWNED(o) with req_valid[o]=0 never grants anyone. Arbitration resumes the following cycle.
  - A request and lock arriving in the same cycle as another requester's release: the arriving requester waits one cycle.
- Reset mid-operation: outstanding reads are discarded, with no rd_valid after reset. Any lock is dropped. SRAM_we_n=1 on the first reset cycle.
- Requesters must not change request fields while req_valid=1 and grant=0.

Test Plan:
1. Req 0 alone reads addr 38400, SRAM model returns 16'hA5A5 → grant[0] same cycle; SRAM_address=38400 next cycle; rd_valid=3'b001 with rd_data=16'hA5A5 exactly 2 cycles later.
2. All three req_valid=1, no lock, for 6 cycles from reset → grant sequence 001,010,100,001,010,100; SRAM_we_n=1 throughout; rd_valid ids return in the same order offset by 2.
3. Req 1 locks for 4 accesses (lock=1,1,1,0) while req 0 and req 2 are valid → four consecutive grant=010, then grant=100 (round-robin after last=1), then 001.
4. MAX_LOCK=4, req 2 holds lock=1 continuously, req 0 valid → 4 grants to req 2, then grant=001 immediately, then req 2 regains.
5. Req 0 writes 16'h1234 to addr 146944, then req 1 reads addr 0 → SRAM_we_n=0 with data 16'h1234 one cycle, SRAM_we_n=1 addr 0 next cycle; rd_valid=010 two cycles later, no rd_valid for the write.
6. Reads from req 1 in flight, Resetn=0 for 1 cycle → rd_valid stays 000 for 4 cycles after reset; SRAM_we_n=1, SRAM_address=0; first post-reset request goes to req 0.
